// File: rtl/rf_param_bypass.sv
// Parametrised 2-read/1-write register file with same-cycle write bypass,
// optional hardwired-zero R0 and a per-register busy scoreboard.
module rf_param_bypass #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NREGS   = 8,
    parameter int unsigned SELW    = 3,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SELW-1:0]  read1RegSel,
    input  logic [SELW-1:0]  read2RegSel,
    input  logic [SELW-1:0]  writeRegSel,
    input  logic [WIDTH-1:0] writeData,
    input  logic             writeEn,
    input  logic             resvEn,
    input  logic [SELW-1:0]  resvRegSel,
    output logic [WIDTH-1:0] read1Data,
    output logic [WIDTH-1:0] read2Data,
    output logic             read1Busy,
    output logic             read2Busy,
    output logic             err
);

    localparam bit FULL_MAP = (NREGS == (32'd1 << SELW));

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;

    logic wr_inr_c;
    logic rv_inr_c;
    logic wr_r0_c;
    logic rv_r0_c;
    logic wr_legal_c;
    logic rv_legal_c;
    logic wr_hits_rv_c;
    logic resv_busy_c;
    logic err_set_c;

    // Range checks collapse to constants when every select value maps to a register
    if (FULL_MAP) begin : g_full
        assign wr_inr_c = 1'b1;
        assign rv_inr_c = 1'b1;
    end else begin : g_part
        localparam logic [SELW-1:0] SEL_LIMIT = SELW'(NREGS);
        assign wr_inr_c = (writeRegSel < SEL_LIMIT);
        assign rv_inr_c = (resvRegSel  < SEL_LIMIT);
    end

    assign wr_r0_c      = ZERO_R0 && (writeRegSel == '0);
    assign rv_r0_c      = ZERO_R0 && (resvRegSel  == '0);
    assign wr_legal_c   = writeEn && wr_inr_c && !wr_r0_c;
    assign rv_legal_c   = resvEn  && rv_inr_c && !rv_r0_c;
    assign wr_hits_rv_c = wr_legal_c && (writeRegSel == resvRegSel);

    // A reservation on a busy register is only legal if this cycle's write releases it
    assign err_set_c = (writeEn && !wr_inr_c)
                     || (resvEn && !rv_inr_c)
                     || (rv_legal_c && resv_busy_c && !wr_hits_rv_c);

    // Read muxes; unmatched selects (out of range) fall through to zero
    always_comb begin
        read1Data   = '0;
        read2Data   = '0;
        read1Busy   = 1'b0;
        read2Busy   = 1'b0;
        resv_busy_c = 1'b0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (read1RegSel == SELW'(i)) begin
                read1Data = regs[i];
                read1Busy = busy[i];
            end
            if (read2RegSel == SELW'(i)) begin
                read2Data = regs[i];
                read2Busy = busy[i];
            end
            if (resvRegSel == SELW'(i)) begin
                resv_busy_c = busy[i];
            end
        end
        if (ZERO_R0 && (read1RegSel == '0)) begin
            read1Data = '0;
            read1Busy = 1'b0;
        end
        if (ZERO_R0 && (read2RegSel == '0)) begin
            read2Data = '0;
            read2Busy = 1'b0;
        end
        if (BYPASS && wr_legal_c && (writeRegSel == read1RegSel)) begin
            read1Data = writeData;
            read1Busy = 1'b0;
        end
        if (BYPASS && wr_legal_c && (writeRegSel == read2RegSel)) begin
            read2Data = writeData;
            read2Busy = 1'b0;
        end
    end

    // Register storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_legal_c) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (writeRegSel == SELW'(i)) begin
                    regs[i] <= writeData;
                end
            end
        end
    end

    // Scoreboard: a new reservation outranks a same-cycle release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (rv_legal_c && (resvRegSel == SELW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wr_legal_c && (writeRegSel == SELW'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    // Sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (err_set_c) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_param_bypass.sv
// Directed and model-checked bench for rf_param_bypass across three parameter sets.
module tb_rf_param_bypass;

    logic clk;
    logic rst;

    // Instance A: 16x8, bypass on, no zero R0
    logic [2:0]  a_r1, a_r2, a_ws, a_rs;
    logic [15:0] a_wd, a_rd1, a_rd2;
    logic        a_we, a_rv, a_b1, a_b2, a_err;

    // Instance B: 16x6, bypass off, zero R0
    logic [2:0]  b_r1, b_r2, b_ws, b_rs;
    logic [15:0] b_wd, b_rd1, b_rd2;
    logic        b_we, b_rv, b_b1, b_b2, b_err;

    // Instance C: 32x16, bypass on, zero R0
    logic [3:0]  c_r1, c_r2, c_ws, c_rs;
    logic [31:0] c_wd, c_rd1, c_rd2;
    logic        c_we, c_rv, c_b1, c_b2, c_err;

    int n_checks;
    int n_fail;

    logic [31:0] m_regs [16];
    logic [15:0] m_busy;
    logic        m_err;
    logic        wl, rl;
    logic [31:0] e1d, e2d;
    logic        e1b, e2b;

    rf_param_bypass #(.WIDTH(16), .NREGS(8), .SELW(3), .BYPASS(1'b1), .ZERO_R0(1'b0)) u_a (
        .clk(clk), .rst(rst),
        .read1RegSel(a_r1), .read2RegSel(a_r2), .writeRegSel(a_ws), .writeData(a_wd),
        .writeEn(a_we), .resvEn(a_rv), .resvRegSel(a_rs),
        .read1Data(a_rd1), .read2Data(a_rd2), .read1Busy(a_b1), .read2Busy(a_b2), .err(a_err)
    );

    rf_param_bypass #(.WIDTH(16), .NREGS(6), .SELW(3), .BYPASS(1'b0), .ZERO_R0(1'b1)) u_b (
        .clk(clk), .rst(rst),
        .read1RegSel(b_r1), .read2RegSel(b_r2), .writeRegSel(b_ws), .writeData(b_wd),
        .writeEn(b_we), .resvEn(b_rv), .resvRegSel(b_rs),
        .read1Data(b_rd1), .read2Data(b_rd2), .read1Busy(b_b1), .read2Busy(b_b2), .err(b_err)
    );

    rf_param_bypass #(.WIDTH(32), .NREGS(16), .SELW(4), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_c (
        .clk(clk), .rst(rst),
        .read1RegSel(c_r1), .read2RegSel(c_r2), .writeRegSel(c_ws), .writeData(c_wd),
        .writeEn(c_we), .resvEn(c_rv), .resvRegSel(c_rs),
        .read1Data(c_rd1), .read2Data(c_rd2), .read1Busy(c_b1), .read2Busy(c_b2), .err(c_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_drv(input logic we, input logic [2:0] ws, input logic [15:0] wd,
                         input logic rv, input logic [2:0] rs,
                         input logic [2:0] r1, input logic [2:0] r2);
        a_we = we; a_ws = ws; a_wd = wd; a_rv = rv; a_rs = rs; a_r1 = r1; a_r2 = r2;
    endtask

    task automatic b_drv(input logic we, input logic [2:0] ws, input logic [15:0] wd,
                         input logic rv, input logic [2:0] rs,
                         input logic [2:0] r1, input logic [2:0] r2);
        b_we = we; b_ws = ws; b_wd = wd; b_rv = rv; b_rs = rs; b_r1 = r1; b_r2 = r2;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        a_drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        b_drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        c_we = 1'b0; c_ws = '0; c_wd = '0; c_rv = 1'b0; c_rs = '0; c_r1 = '0; c_r2 = '0;
        tick();
        tick();
        rst = 1'b1;

        // Reset: dirty busy/err first, then assert reset in the middle of a write
        a_drv(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd3, 3'd0);
        tick();
        tick();
        a_drv(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd3, 3'd0);
        #1;
        check("pre_err", 32'(a_err), 32'd1);
        check("byp_beef", 32'(a_rd1), 32'hBEEF);
        check("byp_busy0", 32'(a_b1), 32'd0);
        rst = 1'b0;
        #1;
        a_we = 1'b0;
        #1;
        check("rst_r3", 32'(a_rd1), 32'd0);
        check("rst_busy", 32'(a_b1), 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        tick();
        check("post_rst_r3", 32'(a_rd1), 32'd0);
        check("post_rst_err", 32'(a_err), 32'd0);

        // Write then read on both ports
        a_drv(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd0, 3'd0);
        tick();
        a_drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd5);
        #1;
        check("wr_r5_p1", 32'(a_rd1), 32'h1234);
        check("wr_r5_p2", 32'(a_rd2), 32'h1234);
        a_r2 = 3'd4;
        #1;
        check("r4_zero", 32'(a_rd2), 32'd0);

        // Bypass on
        a_drv(1'b1, 3'd2, 16'hA5A5, 1'b0, 3'd0, 3'd2, 3'd5);
        #1;
        check("byp_p1", 32'(a_rd1), 32'hA5A5);
        check("byp_p2_other", 32'(a_rd2), 32'h1234);
        tick();
        a_we = 1'b0;
        #1;
        check("byp_after", 32'(a_rd1), 32'hA5A5);

        // Scoreboard
        a_drv(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 3'd6, 3'd0);
        tick();
        a_drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd6, 3'd0);
        #1;
        check("resv_busy", 32'(a_b1), 32'd1);
        a_drv(1'b1, 3'd6, 16'h0606, 1'b1, 3'd6, 3'd7, 3'd0);
        tick();
        a_drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd6, 3'd0);
        #1;
        check("wr_resv_busy", 32'(a_b1), 32'd1);
        check("wr_resv_err", 32'(a_err), 32'd0);
        check("wr_resv_data", 32'(a_rd1), 32'h0606);
        a_drv(1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, 3'd7, 3'd0);
        tick();
        a_drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd6, 3'd0);
        #1;
        check("release_busy", 32'(a_b1), 32'd0);
        check("release_data", 32'(a_rd1), 32'h6666);

        // Double reservation is sticky until reset
        a_drv(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 3'd1, 3'd0);
        tick();
        check("first_resv_err", 32'(a_err), 32'd0);
        tick();
        a_rv = 1'b0;
        #1;
        check("dbl_resv_err", 32'(a_err), 32'd1);
        tick();
        tick();
        check("err_sticky", 32'(a_err), 32'd1);
        rst = 1'b0;
        #1;
        check("err_cleared", 32'(a_err), 32'd0);
        rst = 1'b1;
        tick();

        // No bypass: old value until the edge
        b_drv(1'b1, 3'd2, 16'h1111, 1'b0, 3'd0, 3'd2, 3'd0);
        tick();
        b_drv(1'b1, 3'd2, 16'hA5A5, 1'b0, 3'd0, 3'd2, 3'd0);
        #1;
        check("nbyp_old", 32'(b_rd1), 32'h1111);
        tick();
        b_we = 1'b0;
        #1;
        check("nbyp_new", 32'(b_rd1), 32'hA5A5);

        // Out-of-range write with NREGS=6
        b_drv(1'b1, 3'd7, 16'hDEAD, 1'b0, 3'd0, 3'd7, 3'd2);
        #1;
        check("oor_read", 32'(b_rd1), 32'd0);
        check("oor_err_pre", 32'(b_err), 32'd0);
        tick();
        b_drv(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd2, 3'd1);
        #1;
        check("oor_err", 32'(b_err), 32'd1);
        check("oor_r2_kept", 32'(b_rd1), 32'hA5A5);
        check("oor_r1_kept", 32'(b_rd2), 32'd0);
        b_r1 = 3'd6;
        #1;
        check("oor_read6", 32'(b_rd1), 32'd0);

        // Hardwired-zero R0
        rst = 1'b0;
        #1;
        rst = 1'b1;
        b_drv(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 3'd0);
        #1;
        check("r0_same_cyc", 32'(b_rd1), 32'd0);
        check("r0_busy_same", 32'(b_b1), 32'd0);
        tick();
        b_drv(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0, 3'd0);
        #1;
        check("r0_data", 32'(b_rd1), 32'd0);
        check("r0_busy", 32'(b_b1), 32'd0);
        check("r0_err", 32'(b_err), 32'd0);
        tick();
        b_rv = 1'b0;
        #1;
        check("r0_resv2_err", 32'(b_err), 32'd0);

        // Wide configuration against a reference model
        rst = 1'b0;
        #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_busy = '0;
        m_err  = 1'b0;
        for (int k = 0; k < 300; k++) begin
            c_we = 1'($urandom_range(1, 0));
            c_ws = 4'($urandom_range(15, 0));
            c_wd = $urandom();
            c_rv = ($urandom_range(3, 0) == 0);
            c_rs = 4'($urandom_range(15, 0));
            c_r1 = (k % 4 == 0) ? c_ws : 4'($urandom_range(15, 0));
            c_r2 = 4'($urandom_range(15, 0));
            #1;
            wl  = c_we && (c_ws != 4'd0);
            rl  = c_rv && (c_rs != 4'd0);
            e1d = (c_r1 == 4'd0) ? 32'd0 : (wl && c_ws == c_r1) ? c_wd : m_regs[c_r1];
            e2d = (c_r2 == 4'd0) ? 32'd0 : (wl && c_ws == c_r2) ? c_wd : m_regs[c_r2];
            e1b = (c_r1 == 4'd0) ? 1'b0 : (wl && c_ws == c_r1) ? 1'b0 : m_busy[c_r1];
            e2b = (c_r2 == 4'd0) ? 1'b0 : (wl && c_ws == c_r2) ? 1'b0 : m_busy[c_r2];
            check("rnd_rd1", c_rd1, e1d);
            check("rnd_rd2", c_rd2, e2d);
            check("rnd_b1", 32'(c_b1), 32'(e1b));
            check("rnd_b2", 32'(c_b2), 32'(e2b));
            check("rnd_err", 32'(c_err), 32'(m_err));
            if (rl && m_busy[c_rs] && !(wl && c_ws == c_rs)) m_err = 1'b1;
            if (wl) begin
                m_regs[c_ws] = c_wd;
                m_busy[c_ws] = 1'b0;
            end
            if (rl) m_busy[c_rs] = 1'b1;
            tick();
            if (k % 100 == 99) begin
                rst = 1'b0;
                #1;
                rst = 1'b1;
                for (int i = 0; i < 16; i++) m_regs[i] = '0;
                m_busy = '0;
                m_err  = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
